// File: rtl/gf_inv_pkg.sv
// ============================================================================
// Module   : gf_inv_pkg
// Purpose  : Shared types and constant helpers for the GF(2^M) inverse/Frobenius unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gf_inv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHAIN = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Sub-phase of one addition-chain step inside CHAIN.
  typedef enum logic [1:0] {
    DSQ  = 2'd0,
    DMUL = 2'd1,
    BSQ  = 2'd2,
    BMUL = 2'd3
  } step_t;

  localparam logic [31:0] c_default_poly = 32'h0000_002D;
  localparam int          c_cnt_w        = 6;

  function automatic int bitlen(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic int popcount(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  function automatic int chain_cycles(input int m);
    return (m - 1) + (bitlen(m - 1) - 1) + (popcount(m - 1) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf_mul_comb.sv
// ============================================================================
// Module   : gf_mul_comb
// Purpose  : Combinational GF(2^M) multiply, p = x*y mod (x^M + POLY), Horner form.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mul_comb #(
  parameter int          M    = 16,
  parameter logic [31:0] POLY = 32'h0000_002D
) (
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic [M-1:0] p
);

  localparam logic [M-1:0] c_poly = POLY[M-1:0];

  // Stage i holds the product of y with the top i+1 bits of x, already reduced.
  for (genvar i = 0; i < M; i++) begin : g_stage
    logic [M-1:0] w_acc;
    if (i == 0) begin : g_first
      assign w_acc = x[M-1] ? y : '0;
    end else begin : g_next
      logic [M-1:0] w_prev;
      assign w_prev = g_stage[i-1].w_acc;
      assign w_acc  = {w_prev[M-2:0], 1'b0}
                    ^ (w_prev[M-1] ? c_poly : '0)
                    ^ (x[M-1-i]    ? y      : '0);
    end
  end

  assign p = g_stage[M-1].w_acc;

endmodule

`default_nettype wire

// File: rtl/gf_inv_frob_seq.sv
// ============================================================================
// Module   : gf_inv_frob_seq
// Purpose  : Sequential GF(2^M) Itoh-Tsujii inverse or Frobenius a^(2^n), one shared multiplier.
//            Optional macro GF_INV_ZERO_FLAG_EN adds out_zero and a 1-cycle zero-inverse shortcut.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_inv_frob_seq
  import gf_inv_pkg::*;
#(
  parameter int          M    = 16,
  parameter logic [31:0] POLY = c_default_poly,
  parameter int          NW   = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [NW-1:0] in_n,
  input  logic [M-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          busy
`ifdef GF_INV_ZERO_FLAG_EN
  ,
  output logic          out_zero
`endif
);

  localparam int                 c_bl        = bitlen(M - 1);
  localparam logic [7:0]         c_mm1       = 8'(M - 1);
  localparam logic [2:0]         c_start_idx = (c_bl >= 2) ? 3'(c_bl - 2) : 3'd0;
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  state_t               r_state;
  step_t                r_step;
  logic                 r_op;
  logic [M-1:0]         r_a;
  logic [M-1:0]         r_beta;
  logic [M-1:0]         r_beta_k;
  logic [c_cnt_w-1:0]   r_k;
  logic [c_cnt_w-1:0]   r_sq_cnt;
  logic [2:0]           r_bit_idx;
  logic [M-1:0]         r_out_data;
  logic                 r_out_valid;
  logic [M-1:0]         w_y;
  logic [M-1:0]         w_p;
`ifdef GF_INV_ZERO_FLAG_EN
  logic                 r_zero;
  logic                 r_out_zero;
`endif

  // Multiplier operand select: squaring unless an inverse chain multiply step.
  always_comb begin
    w_y = r_beta;
    if (r_state == CHAIN && !r_op && r_step == DMUL) begin
      w_y = r_beta_k;
    end else if (r_state == CHAIN && !r_op && r_step == BMUL) begin
      w_y = r_a;
    end
  end

  gf_mul_comb #(
    .M    (M),
    .POLY (POLY)
  ) u_mul (
    .x (r_beta),
    .y (w_y),
    .p (w_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= DSQ;
      r_op        <= 1'b0;
      r_a         <= '0;
      r_beta      <= '0;
      r_beta_k    <= '0;
      r_k         <= '0;
      r_sq_cnt    <= '0;
      r_bit_idx   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
      r_zero      <= 1'b0;
      r_out_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= in_data;
            r_beta    <= in_data;
            r_beta_k  <= in_data;
            r_op      <= in_op;
            r_k       <= c_one;
            r_sq_cnt  <= in_op ? c_cnt_w'(in_n) : c_one;
            r_bit_idx <= c_start_idx;
            r_step    <= DSQ;
`ifdef GF_INV_ZERO_FLAG_EN
            r_zero    <= !in_op && (in_data == '0);
            if (!in_op && (in_data == '0 || c_bl < 2)) r_state <= FINAL;
            else                                       r_state <= CHAIN;
`else
            if (!in_op && c_bl < 2) r_state <= FINAL;
            else                    r_state <= CHAIN;
`endif
          end
        end

        CHAIN: begin
          if (r_op) begin
            // Frobenius: n squarings, the last one written straight to the output.
            if (r_sq_cnt <= c_one) begin
              r_out_data  <= (r_sq_cnt == '0) ? r_beta : w_p;
              r_out_valid <= 1'b1;
`ifdef GF_INV_ZERO_FLAG_EN
              r_out_zero  <= 1'b0;
`endif
              r_state     <= HOLD;
            end else begin
              r_beta   <= w_p;
              r_sq_cnt <= r_sq_cnt - c_one;
            end
          end else begin
            r_beta <= w_p;
            case (r_step)
              DSQ: begin
                if (r_sq_cnt == c_one) r_step <= DMUL;
                else                   r_sq_cnt <= r_sq_cnt - c_one;
              end
              DMUL: begin
                r_k <= r_k << 1;
                if (c_mm1[r_bit_idx]) begin
                  r_step <= BSQ;
                end else if (r_bit_idx == 3'd0) begin
                  r_state <= FINAL;
                end else begin
                  r_bit_idx <= r_bit_idx - 3'd1;
                  r_step    <= DSQ;
                  r_sq_cnt  <= r_k << 1;
                  r_beta_k  <= w_p;
                end
              end
              BSQ: begin
                r_step <= BMUL;
              end
              default: begin
                r_k <= r_k + c_one;
                if (r_bit_idx == 3'd0) begin
                  r_state <= FINAL;
                end else begin
                  r_bit_idx <= r_bit_idx - 3'd1;
                  r_step    <= DSQ;
                  r_sq_cnt  <= r_k + c_one;
                  r_beta_k  <= w_p;
                end
              end
            endcase
          end
        end

        FINAL: begin
          // beta = a^(2^(M-1)-1); one more squaring gives a^(2^M-2).
          r_out_data  <= w_p;
          r_out_valid <= 1'b1;
`ifdef GF_INV_ZERO_FLAG_EN
          r_out_zero  <= r_zero;
`endif
          r_state     <= HOLD;
        end

        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef GF_INV_ZERO_FLAG_EN
  assign out_zero  = r_out_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf_inv_frob_seq.sv
// ============================================================================
// Module   : tb_gf_inv_frob_seq
// Purpose  : Self-checking bench for gf_inv_frob_seq (M=16): vector table, corner sequences, random vs. model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_inv_frob_seq;
  import gf_inv_pkg::*;

  localparam int          M     = 16;
  localparam int          NW    = 4;
  localparam logic [15:0] POLY  = 16'h002D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [NW-1:0] in_n = '0;
  logic [M-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [M-1:0]  out_data;
  logic          busy;
`ifdef GF_INV_ZERO_FLAG_EN
  logic          out_zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf_inv_frob_seq #(.M(M), .POLY(32'h0000_002D), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_n      (in_n),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef GF_INV_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: schoolbook polynomial product reduced bit by bit.
  function automatic logic [15:0] mmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    prod = '0;
    for (int i = 0; i < 16; i++) if (b[i]) prod = prod ^ (32'(a) << i);
    for (int i = 30; i >= 16; i--) if (prod[i]) prod = prod ^ ((32'h10000 | 32'(POLY)) << (i - 16));
    return prod[15:0];
  endfunction

  function automatic logic [15:0] mfrob(input logic [15:0] a, input int n);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = mmul(r, r);
    return r;
  endfunction

  // Fermat inverse a^(2^16-2) by plain square-and-multiply over the exponent.
  function automatic logic [15:0] minv(input logic [15:0] a);
    logic [15:0] r, b;
    int e;
    r = 16'h0001; b = a; e = (1 << M) - 2;
    while (e != 0) begin
      if (e[0]) r = mmul(r, b);
      b = mmul(b, b);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic op, input int n, input logic [15:0] a);
    int v, bl;
    if (op) return (n == 0) ? 1 : n;
`ifdef GF_INV_ZERO_FLAG_EN
    if (a == 16'h0) return 1;
`endif
    v = M - 1; bl = 0;
    while ((v >> bl) != 0) bl++;
    return (M - 1) + (bl - 1) + ($countones(v) - 1);
  endfunction

  task automatic run_req(input logic op, input logic [NW-1:0] n, input logic [15:0] a, input int hold,
                         output logic [15:0] data, output int lat, output logic zf);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_n = n; in_data = a;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_op = 1'($urandom); in_n = NW'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    data = out_data;
`ifdef GF_INV_ZERO_FLAG_EN
    zf = out_zero;
`else
    zf = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_data", 32'(out_data), 32'(data));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic        op;
    logic [3:0]  n;
    logic [15:0] a;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl [8];
    logic [15:0] d;
    int          lat;
    logic        zf;
    int          spurious;
    logic        op;
    logic [3:0]  n;
    logic [15:0] a;

    tbl[0] = '{1'b0, 4'd0,  16'h0001, 16'h0001, 21};
    tbl[1] = '{1'b0, 4'd0,  16'h0002, 16'h8016, 21};
    tbl[2] = '{1'b0, 4'd0,  16'h8016, 16'h0002, 21};
    tbl[3] = '{1'b1, 4'd1,  16'h0100, 16'h002D, 1};
    tbl[4] = '{1'b1, 4'd4,  16'h0002, 16'h002D, 4};
    tbl[5] = '{1'b1, 4'd0,  16'h1234, 16'h1234, 1};
    tbl[6] = '{1'b1, 4'd8,  16'h0004, 16'h0002 << 0 ^ 16'h0000, 0};
`ifdef GF_INV_ZERO_FLAG_EN
    tbl[7] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1};
`else
    tbl[7] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 21};
`endif
    // (x^2)^(2^8) = x^512; fill from the model, latency 8.
    tbl[6].exp = mfrob(16'h0004, 8);
    tbl[6].lat = 8;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("model_2_times_inv", 32'(mmul(16'h0002, 16'h8016)), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].op, tbl[i].n, tbl[i].a, 0, d, lat, zf);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
`ifdef GF_INV_ZERO_FLAG_EN
      chk($sformatf("vec%0d_zero", i), 32'(zf), 32'(!tbl[i].op && tbl[i].a == 16'h0));
`endif
    end

    // Backpressure then back-to-back accept on the cycle after the handshake.
    run_req(1'b0, 4'd0, 16'h0003, 5, d, lat, zf);
    chk("bp_data", 32'(d), 32'(minv(16'h0003)));
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    run_req(1'b1, 4'd2, 16'h0003, 0, d, lat, zf);
    chk("b2b_data", 32'(d), 32'(mfrob(16'h0003, 2)));
    chk("b2b_lat", 32'(lat), 32'd2);

    // Reset during an inverse aborts it with no result.
    in_valid = 1'b1; in_op = 1'b0; in_n = '0; in_data = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    spurious = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) spurious++; end
    chk("abort_no_result", 32'(spurious), 32'd0);

    for (int i = 0; i < 150; i++) begin
      op = 1'($urandom);
      n  = 4'($urandom_range(0, 15));
      a  = (i % 37 == 5) ? 16'h0 : 16'($urandom);
      run_req(op, n, a, int'($urandom_range(0, 2)), d, lat, zf);
      if (op) begin
        chk("rnd_frob_data", 32'(d), 32'(mfrob(a, int'(n))));
      end else begin
        chk("rnd_inv_data", 32'(d), 32'(minv(a)));
        chk("rnd_inv_product", 32'(mmul(a, d)), (a != 16'h0) ? 32'd1 : 32'd0);
      end
      chk("rnd_lat", 32'(lat), 32'(exp_lat(op, int'(n), a)));
`ifdef GF_INV_ZERO_FLAG_EN
      chk("rnd_zero", 32'(zf), 32'(!op && a == 16'h0));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf_inv_frob_seq.md
Name: gf_inv_frob_seq

Overview:
- Sequential GF(2^M) unit that computes the field inverse by Itoh-Tsujii, or the Frobenius power a^(2^n) for a run-time n.
- Supersedes the fixed exp1/exp3/exp6 combinational maps with a field width parameter, polynomial parameter and run-time exponent.
- One shared combinational multiplier is iterated under an FSM.
- Sits in the ALU inverse path of the Niederreiter cryptoprocessor, with a valid/ready handshake on both sides.

Parameters:
- M, 16, field degree (2..32).
- POLY, 32'h0000_002D, low M bits of the irreducible polynomial, x^M term implicit. Default is x^16+x^5+x^3+x^2+1.
- NW, $clog2(M), width of in_n.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit idle and accepting a request.
- in_op  in  1  0 = inverse, 1 = Frobenius a^(2^n).
- in_n  in  NW  Frobenius exponent count n; ignored when in_op=0.
- in_data  in  M  operand a.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  M  result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset mid-operation aborts the operation; no result is produced.
- Accept: a request is taken on the edge where in_valid & in_ready are both high.
  - a, op and n are registered.
  - in_ready = (state==IDLE).
- FSM states: IDLE, CHAIN, FINAL, HOLD.
- Datapath: one multiplier, gf_mul_comb, computes P = X*Y mod POLY. Squaring is X=Y.
  - Registers: beta (M bits), k (chain exponent), sq_cnt, bit_idx (pointer into M-1).
- Inverse (op=0): beta=a, k=1. Scan the bits of M-1 from MSB-1 down to bit 0.
  - Doubling: square beta k times, one cycle each, then one multiply by saved beta_k. k = 2k.
  - If the scanned bit is 1: one square, then one multiply by a. k = k+1.
  - FINAL: one square. Result is a^(2^M-2).
  - Cycle count = (M-1) squares + (bitlen(M-1)-1 + popcount(M-1)-1) multiplies.
  - For M=16: 15+6 = 21 cycles. out_valid rises on the 21st edge after the accept edge.
- Frobenius (op=1): square beta n times, one per cycle.
  - n=0: result = a, latency 1 cycle. Latency is max(n,1).
  - n >= M is legal and is simply iterated.
- HOLD: out_valid=1 and out_data stable until out_ready=1.
  - On that edge: out_valid goes to 0 and state goes to IDLE.
  - in_ready stays 0 while in HOLD (no overlap). A new accept is possible on the next cycle.
- Zero operand: inverse of 0 is 0, with the full latency. This is the natural result of the chain.
- in_data/in_op/in_n changes after accept have no effect.

Optional Feature:
- Macro: GF_INV_ZERO_FLAG_EN.
- Defined:
  - Adds output out_zero (1 bit, reset 0), valid together with out_valid.
  - An inverse request with a==0 skips CHAIN/FINAL and enters HOLD after 1 cycle with out_data=0 and out_zero=1.
  - out_zero=0 for all other results.
- Undefined:
  - No port.
  - Zero takes the full chain and returns 0.

Decomposition:
- gf_inv_pkg holds:
  - state enum (IDLE/CHAIN/FINAL/HOLD);
  - default POLY for M=16;
  - function chain_cycles(M) returning the inverse latency;
  - function popcount/bitlen helpers for the bench.
- Sub-module gf_mul_comb #(M,POLY): combinational M×M polynomial multiply plus modular reduction, built with generate loops.

Test Plan:
- Inverse of 0x0001 -> out_data=0x0001, out_valid exactly 21 cycles after the accept.
- Inverse of 0x0002 -> 0x8016. Check that 0x0002*0x8016 = 1.
- Frobenius op=1, n=1, a=0x0100 -> 0x002D, latency 1. Frobenius n=4, a=0x0002 -> 0x002D, latency 4. Frobenius n=0, a=0x1234 -> 0x1234, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout. Accept a new request the cycle after the handshake.
- Assert rst at cycle 10 of an inverse -> next edge gives out_valid=0, in_ready=1, busy=0, and no spurious result.
- Sweep all 65535 nonzero a: a*out_data = 1 under the golden model. With GF_INV_ZERO_FLAG_EN, a=0 -> out_data=0, out_zero=1, latency 1; without the macro, a=0 -> out_data=0, latency 21.
